// File: rtl/spi_master_fifo.sv
// SPI master with TX/RX FIFOs, configurable prescaler/mode/bit order and CS_NUM slave selects.
// Optional macro SPI_MASTER_RX_STALL_EN: hold transfers while the RX FIFO is full instead of dropping words.
module spi_master_fifo #(
  parameter int WORD_LEN   = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CS_NUM     = 4,
  localparam int CS_W      = (CS_NUM > 1) ? $clog2(CS_NUM) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WORD_LEN-1:0] data_in,
  input  logic                wr,
  output logic [WORD_LEN-1:0] data_out,
  input  logic                rd,
  output logic                tx_full,
  output logic                tx_empty,
  output logic                rx_full,
  output logic                rx_empty,
  output logic                senderr,
  output logic                overrun,
  input  logic                res_err,
  input  logic [2:0]          prescaller,
  input  logic [1:0]          mode,
  input  logic                lsbfirst,
  input  logic [CS_W-1:0]     cs_sel,
  output logic                busy,
  output logic                sck,
  output logic                mosi,
  input  logic                miso,
  output logic [CS_NUM-1:0]   ss,
  output logic [1:0]          state_dbg
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(2 * WORD_LEN + 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, TAIL} state_t;
  state_t state;

  // wr and rd are single-cycle strobes sampled on posedge clk; a push is taken only when
  // !tx_full and a pop only when !rx_empty, so the flags act as ready and the strobes as valid.
  logic [WORD_LEN-1:0] tx_mem [FIFO_DEPTH];
  logic [WORD_LEN-1:0] rx_mem [FIFO_DEPTH];
  logic [AW-1:0]       tx_wp, tx_rp, rx_wp, rx_rp;
  logic [AW:0]         tx_cnt, rx_cnt;

  logic [2:0]          cfg_pre;
  logic                cfg_cpha, cfg_lsb;
  logic [CS_W-1:0]     cfg_cs;
  logic [7:0]          div_cnt, half;
  logic [TW-1:0]       tog_cnt;
  logic [WORD_LEN-1:0] tx_sh, rx_sh, rx_next, rx_word, tx_head;
  logic [CS_NUM-1:0]   ss_val;
  logic                half_end, last_tog, sample_now, shift_now;
  logic                tx_push, tx_pop, rx_push, rx_pop, rx_drop, can_load;

  function automatic logic first_bit(input logic [WORD_LEN-1:0] w, input logic lsb);
    return lsb ? w[0] : w[WORD_LEN-1];
  endfunction

  function automatic logic [WORD_LEN-1:0] adv(input logic [WORD_LEN-1:0] w, input logic lsb);
    return lsb ? (w >> 1) : (w << 1);
  endfunction

  assign tx_empty  = (tx_cnt == '0);
  assign tx_full   = (tx_cnt == (AW+1)'(FIFO_DEPTH));
  assign rx_empty  = (rx_cnt == '0);
  assign rx_full   = (rx_cnt == (AW+1)'(FIFO_DEPTH));
  assign data_out  = rx_empty ? '0 : rx_mem[rx_rp];
  assign tx_head   = tx_mem[tx_rp];
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  assign half       = 8'd1 << cfg_pre;
  assign half_end   = (div_cnt == half - 8'd1);
  assign last_tog   = (state == SHIFT) && half_end && (tog_cnt == TW'(2 * WORD_LEN - 1));
  // Toggle number is tog_cnt+1, so an even tog_cnt marks an odd (leading) toggle.
  assign sample_now = (state == SHIFT) && half_end && (tog_cnt[0] == cfg_cpha);
  assign shift_now  = (state == SHIFT) && half_end && (tog_cnt[0] != cfg_cpha) && !last_tog;
  assign rx_next    = cfg_lsb ? {miso, rx_sh[WORD_LEN-1:1]} : {rx_sh[WORD_LEN-2:0], miso};
  assign rx_word    = sample_now ? rx_next : rx_sh;

  assign tx_push = wr && !tx_full;
  assign tx_pop  = (state == LOAD);
  assign rx_push = last_tog && !rx_full;
  assign rx_pop  = rd && !rx_empty;
`ifdef SPI_MASTER_RX_STALL_EN
  assign can_load = !rx_full;
  assign rx_drop  = 1'b0;
`else
  assign can_load = 1'b1;
  assign rx_drop  = last_tog && rx_full;
`endif

  always_comb begin
    ss_val = '1;
    for (int i = 0; i < CS_NUM; i++) begin
      if (cfg_cs == CS_W'(i)) ss_val[i] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
    end else begin
      if (tx_push) begin
        tx_mem[tx_wp] <= data_in;
        tx_wp         <= tx_wp + 1'b1;
      end
      if (tx_pop) tx_rp <= tx_rp + 1'b1;
      tx_cnt <= tx_cnt + (AW+1)'(tx_push) - (AW+1)'(tx_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
    end else begin
      if (rx_push) begin
        rx_mem[rx_wp] <= rx_word;
        rx_wp         <= rx_wp + 1'b1;
      end
      if (rx_pop) rx_rp <= rx_rp + 1'b1;
      rx_cnt <= rx_cnt + (AW+1)'(rx_push) - (AW+1)'(rx_pop);
    end
  end

  // A new error in the same cycle as res_err keeps the flag set.
  always_ff @(posedge clk) begin
    if (!rst) begin
      senderr <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (wr && tx_full) senderr <= 1'b1;
      else if (res_err)  senderr <= 1'b0;
      if (rx_drop)       overrun <= 1'b1;
      else if (res_err)  overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      sck      <= 1'b0;
      mosi     <= 1'b1;
      ss       <= '1;
      div_cnt  <= '0;
      tog_cnt  <= '0;
      cfg_pre  <= '0;
      cfg_cpha <= 1'b0;
      cfg_lsb  <= 1'b0;
      cfg_cs   <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
    end else begin
      case (state)
        IDLE: begin
          cfg_pre  <= prescaller;
          cfg_cpha <= mode[0];
          cfg_lsb  <= lsbfirst;
          cfg_cs   <= cs_sel;
          sck      <= mode[1];
          mosi     <= 1'b1;
          ss       <= '1;
          if (!tx_empty && can_load) state <= LOAD;
        end
        LOAD: begin
          ss      <= ss_val;
          div_cnt <= '0;
          tog_cnt <= '0;
          rx_sh   <= '0;
          if (cfg_cpha) begin
            tx_sh <= tx_head;
          end else begin
            mosi  <= first_bit(tx_head, cfg_lsb);
            tx_sh <= adv(tx_head, cfg_lsb);
          end
          state <= SHIFT;
        end
        SHIFT: begin
          if (half_end) begin
            div_cnt <= '0;
            sck     <= ~sck;
            tog_cnt <= tog_cnt + 1'b1;
            if (sample_now) rx_sh <= rx_next;
            if (shift_now) begin
              mosi  <= first_bit(tx_sh, cfg_lsb);
              tx_sh <= adv(tx_sh, cfg_lsb);
            end
            if (last_tog) state <= TAIL;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        TAIL: begin
          // When stalled on a full RX FIFO the counter parks at its end value with ss held low.
          if (half_end) begin
            if (!tx_empty && can_load) begin
              div_cnt <= '0;
              state   <= LOAD;
            end else if (tx_empty) begin
              div_cnt <= '0;
              ss      <= '1;
              state   <= IDLE;
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
